// File: rtl/acc_bus_master_pkg.sv
// acc_bus_master_pkg
// Shared constants for the accumulator bus master: command encodings,
// FSM state encodings, ALU opcode/status widths and the LD opcode value.
package acc_bus_master_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int OPCODE_WIDTH   = 5;
    localparam int STATUS_WIDTH   = 4;

    typedef enum logic [1:0] {
        CMD_LOAD    = 2'd0,
        CMD_EXEC    = 2'd1,
        CMD_STORE   = 2'd2,
        CMD_ILLEGAL = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_EXE  = 3'd2,
        ST_RD   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // Opcode the accumulator runs when the latch enable is low.
    localparam logic [OPCODE_WIDTH-1:0] ALU_OP_LD = '0;

endpackage

// File: rtl/acc_bus_master.sv
// acc_bus_master
// Bus-side initiator for the accumulator. Accepts one command at a time
// (LOAD / EXEC / STORE) over a valid/ready handshake, sequences the
// accumulator strobes and the shared data bus, and returns a response.
//
// state | meaning
// IDLE  | ready for a command, no strobes
// WR    | drive cmd_data onto the bus, acc_cs/acc_we high (accumulator LD)
// EXE   | latch ALU opcode into the accumulator, sample acc_status
// RD    | accumulator drives the bus (acc_cs/acc_oe), sample bus_in
// RESP  | hold response until rsp_ready
//
// Ports:
//   clk, reset (async, active low)
//   cmd_valid/cmd_ready/cmd_op/cmd_data/cmd_alu_op : command handshake
//   rsp_valid/rsp_ready/rsp_data/rsp_status/rsp_err : response handshake
//   acc_cs/acc_we/acc_oe/acc_opcode_le/acc_opcode    : accumulator strobes
//   acc_status                                      : ALU status input
//   bus_out/bus_oe                                  : drive side of the external data bus tristate
//   bus_in                                          : data bus sample
//
// All outputs are registered: the output decode works on the next state so
// each registered output is valid for the whole cycle of its state.
module acc_bus_master
    import acc_bus_master_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
    input  logic [OPCODE_WIDTH-1:0] cmd_alu_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [STATUS_WIDTH-1:0] rsp_status,
    output logic                    rsp_err,
    output logic                    acc_cs,
    output logic                    acc_we,
    output logic                    acc_oe,
    output logic                    acc_opcode_le,
    output logic [OPCODE_WIDTH-1:0] acc_opcode,
    input  logic [STATUS_WIDTH-1:0] acc_status,
    output logic [DATA_WIDTH-1:0]   bus_out,
    output logic                    bus_oe,
    input  logic [DATA_WIDTH-1:0]   bus_in
);

    state_e state, state_n;

    logic                    cmd_ready_d;
    logic                    rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_d;
    logic [STATUS_WIDTH-1:0] rsp_status_d;
    logic                    rsp_err_d;
    logic                    acc_cs_d;
    logic                    acc_we_d;
    logic                    acc_oe_d;
    logic                    acc_opcode_le_d;
    logic [OPCODE_WIDTH-1:0] acc_opcode_d;
    logic [DATA_WIDTH-1:0]   bus_out_d;
    logic                    bus_oe_d;

    // cmd_ready is itself registered and only high in IDLE, so it also
    // blocks acceptance on the first cycle after reset release.
    logic accept;
    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_status    <= '0;
            rsp_err       <= 1'b0;
            acc_cs        <= 1'b0;
            acc_we        <= 1'b0;
            acc_oe        <= 1'b0;
            acc_opcode_le <= 1'b0;
            acc_opcode    <= '0;
            bus_out       <= '0;
            bus_oe        <= 1'b0;
        end else begin
            state         <= state_n;
            cmd_ready     <= cmd_ready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_data      <= rsp_data_d;
            rsp_status    <= rsp_status_d;
            rsp_err       <= rsp_err_d;
            acc_cs        <= acc_cs_d;
            acc_we        <= acc_we_d;
            acc_oe        <= acc_oe_d;
            acc_opcode_le <= acc_opcode_le_d;
            acc_opcode    <= acc_opcode_d;
            bus_out       <= bus_out_d;
            bus_oe        <= bus_oe_d;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op_e'(cmd_op))
                        CMD_LOAD:  state_n = ST_WR;
                        CMD_EXEC:  state_n = ST_EXE;
                        CMD_STORE: state_n = ST_RD;
                        default:   state_n = ST_RESP;
                    endcase
                end
            end
            ST_WR, ST_EXE, ST_RD: state_n = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // WR/EXE/RD are only entered from IDLE on an accept, so the command
    // inputs are captured straight into the strobe/bus registers here.
    always_comb begin
        cmd_ready_d     = 1'b0;
        rsp_valid_d     = 1'b0;
        rsp_data_d      = '0;
        rsp_status_d    = '0;
        rsp_err_d       = 1'b0;
        acc_cs_d        = 1'b0;
        acc_we_d        = 1'b0;
        acc_oe_d        = 1'b0;
        acc_opcode_le_d = 1'b0;
        acc_opcode_d    = ALU_OP_LD;
        bus_out_d       = '0;
        bus_oe_d        = 1'b0;
        case (state_n)
            ST_IDLE: cmd_ready_d = 1'b1;
            ST_WR: begin
                acc_cs_d  = 1'b1;
                acc_we_d  = 1'b1;
                bus_oe_d  = 1'b1;
                bus_out_d = cmd_data;
            end
            ST_EXE: begin
                acc_opcode_le_d = 1'b1;
                acc_opcode_d    = cmd_alu_op;
            end
            ST_RD: begin
                acc_cs_d = 1'b1;
                acc_oe_d = 1'b1;
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                case (state)
                    ST_EXE:  rsp_status_d = acc_status;
                    ST_RD:   rsp_data_d   = bus_in;
                    ST_IDLE: rsp_err_d    = 1'b1;
                    ST_RESP: begin
                        rsp_data_d   = rsp_data;
                        rsp_status_d = rsp_status;
                        rsp_err_d    = rsp_err;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_acc_bus_master.sv
// tb_acc_bus_master
// Self-checking bench for acc_bus_master: scenario tasks drive commands and
// check strobe timing inline; a scoreboard queue holds expected responses
// which a monitor pops on each response handshake. A second monitor checks
// the bus protocol invariants every cycle.
module tb_acc_bus_master;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic [4:0]    cmd_alu_op;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [3:0]    rsp_status;
    logic          rsp_err;
    logic          acc_cs, acc_we, acc_oe, acc_opcode_le;
    logic [4:0]    acc_opcode;
    logic [3:0]    acc_status;
    logic [DW-1:0] bus_out;
    logic          bus_oe;
    logic [DW-1:0] bus_in;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int accept_cycle = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    status;
        logic          err;
    } exp_t;

    exp_t sb[$];

    acc_bus_master #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_alu_op(cmd_alu_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .rsp_err(rsp_err),
        .acc_cs(acc_cs), .acc_we(acc_we), .acc_oe(acc_oe),
        .acc_opcode_le(acc_opcode_le), .acc_opcode(acc_opcode),
        .acc_status(acc_status), .bus_out(bus_out), .bus_oe(bus_oe),
        .bus_in(bus_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Scoreboard: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset && rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected data=%h status=%b err=%b", rsp_data, rsp_status, rsp_err);
            end else begin
                e = sb.pop_front();
                if (rsp_data !== e.data || rsp_status !== e.status || rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL rsp_fields got data=%h status=%b err=%b want data=%h status=%b err=%b",
                             rsp_data, rsp_status, rsp_err, e.data, e.status, e.err);
                end
            end
        end
    end

    // Protocol invariants plus bus turnaround (>=2 idle cycles between drivers).
    int gap = 99;
    always @(negedge clk) begin
        checks++;
        if ((acc_we && acc_opcode_le) || (bus_oe && acc_oe) || (!acc_opcode_le && acc_opcode !== 5'd0)) begin
            errors++;
            $display("FAIL invariant we=%b le=%b bus_oe=%b acc_oe=%b opcode=%h",
                     acc_we, acc_opcode_le, bus_oe, acc_oe, acc_opcode);
        end
        if (bus_oe) gap = 0;
        else if (acc_oe) begin
            checks++;
            if (gap < 2) begin
                errors++;
                $display("FAIL turnaround gap=%0d required>=2", gap);
            end
        end else if (gap < 99) gap++;
    end

    task automatic issue(input logic [1:0] op, input logic [DW-1:0] data, input logic [4:0] aop,
                         input logic [DW-1:0] ed, input logic [3:0] es, input logic ee, input bit push);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL issue_timeout cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_data   = data;
        cmd_alu_op = aop;
        if (push) sb.push_back('{ed, es, ee});
        @(posedge clk); #1;
        cmd_valid    = 1'b0;
        accept_cycle = cycle;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, acc_cs, acc_we, acc_oe, acc_opcode_le, bus_oe, rsp_err} !== 8'b0 ||
            bus_out !== '0 || rsp_data !== '0 || rsp_status !== '0 || acc_opcode !== '0) begin
            errors++;
            $display("FAIL reset_values ready=%b valid=%b cs=%b we=%b oe=%b le=%b bus_oe=%b required all 0",
                     cmd_ready, rsp_valid, acc_cs, acc_we, acc_oe, acc_opcode_le, bus_oe);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready cmd_ready=%b required 1", cmd_ready);
        end
        // Reset in the middle of a STORE's RD cycle; its response is discarded.
        bus_in = 8'h99;
        issue(2'd2, 8'h00, 5'h00, 8'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (acc_oe !== 1'b1 || acc_cs !== 1'b1) begin
            errors++;
            $display("FAIL mid_rd_entry acc_oe=%b acc_cs=%b required 1 1", acc_oe, acc_cs);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({acc_cs, acc_we, acc_oe, acc_opcode_le, bus_oe, rsp_valid, cmd_ready} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset cs=%b we=%b oe=%b le=%b bus_oe=%b valid=%b ready=%b required all 0",
                     acc_cs, acc_we, acc_oe, acc_opcode_le, bus_oe, rsp_valid, cmd_ready);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || acc_oe !== 1'b0) begin
            errors++;
            $display("FAIL mid_rd_release ready=%b valid=%b acc_oe=%b required 1 0 0", cmd_ready, rsp_valid, acc_oe);
        end
        bus_in = 8'h00;
    endtask

    task automatic test_load();
        issue(2'd0, 8'hA5, 5'h00, 8'h00, 4'h0, 1'b0, 1'b1);
        checks++;
        if (acc_cs !== 1'b1 || acc_we !== 1'b1 || bus_oe !== 1'b1 || bus_out !== 8'hA5 ||
            acc_opcode_le !== 1'b0 || acc_oe !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_strobe cs=%b we=%b bus_oe=%b bus_out=%h le=%b oe=%b ready=%b valid=%b required 1 1 1 a5 0 0 0 0",
                     acc_cs, acc_we, bus_oe, bus_out, acc_opcode_le, acc_oe, cmd_ready, rsp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || acc_cs !== 1'b0 || bus_oe !== 1'b0) begin
            errors++;
            $display("FAIL load_rsp_timing valid=%b cs=%b bus_oe=%b required 1 0 0", rsp_valid, acc_cs, bus_oe);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_return_idle ready=%b valid=%b required 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_exec();
        acc_status = 4'b0101;
        issue(2'd1, 8'h00, 5'h03, 8'h00, 4'b1010, 1'b0, 1'b1);
        acc_status = 4'b1010;
        checks++;
        if (acc_opcode_le !== 1'b1 || acc_opcode !== 5'h03 || acc_we !== 1'b0 || acc_cs !== 1'b0 || bus_oe !== 1'b0) begin
            errors++;
            $display("FAIL exec_strobe le=%b opcode=%h we=%b cs=%b bus_oe=%b required 1 03 0 0 0",
                     acc_opcode_le, acc_opcode, acc_we, acc_cs, bus_oe);
        end
        @(posedge clk); #1;
        acc_status = 4'b0101;
        checks++;
        if (rsp_valid !== 1'b1 || acc_opcode_le !== 1'b0) begin
            errors++;
            $display("FAIL exec_rsp_timing valid=%b le=%b required 1 0", rsp_valid, acc_opcode_le);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        bus_in = 8'h00;
        issue(2'd2, 8'h00, 5'h00, 8'h3C, 4'h0, 1'b0, 1'b1);
        bus_in = 8'h3C;
        checks++;
        if (acc_cs !== 1'b1 || acc_oe !== 1'b1 || bus_oe !== 1'b0 || acc_we !== 1'b0) begin
            errors++;
            $display("FAIL store_strobe cs=%b oe=%b bus_oe=%b we=%b required 1 1 0 0", acc_cs, acc_oe, bus_oe, acc_we);
        end
        @(posedge clk); #1;
        bus_in = 8'h77;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL store_rsp_timing valid=%b required 1", rsp_valid);
        end
        @(posedge clk); #1;
        bus_in = 8'h00;
    endtask

    task automatic test_illegal();
        issue(2'd3, 8'hFF, 5'h1F, 8'h00, 4'h0, 1'b1, 1'b1);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 ||
            {acc_cs, acc_we, acc_oe, acc_opcode_le, bus_oe} !== 5'b0) begin
            errors++;
            $display("FAIL illegal_rsp valid=%b err=%b strobes=%b required 1 1 00000",
                     rsp_valid, rsp_err, {acc_cs, acc_we, acc_oe, acc_opcode_le, bus_oe});
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_return_idle ready=%b err=%b required 1 0", cmd_ready, rsp_err);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        issue(2'd0, 8'h5A, 5'h00, 8'h00, 4'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h00 || rsp_err !== 1'b0 || cmd_ready !== 1'b0 || acc_oe !== 1'b0) begin
                errors++;
                $display("FAIL load_hold[%0d] valid=%b data=%h err=%b ready=%b acc_oe=%b required 1 00 0 0 0",
                         i, rsp_valid, rsp_data, rsp_err, cmd_ready, acc_oe);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || acc_oe !== 1'b0) begin
            errors++;
            $display("FAIL ignored_cmd ready=%b acc_oe=%b required 1 0", cmd_ready, acc_oe);
        end
        rsp_ready = 1'b0;
        issue(2'd2, 8'h00, 5'h00, 8'hE7, 4'h0, 1'b0, 1'b1);
        bus_in = 8'hE7;
        @(posedge clk); #1;
        bus_in = 8'h18;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'hE7 || rsp_status !== 4'h0 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL store_hold[%0d] valid=%b data=%h status=%b ready=%b required 1 e7 0000 0",
                         i, rsp_valid, rsp_data, rsp_status, cmd_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus_in = 8'h00;
    endtask

    task automatic test_back_to_back();
        int prev;
        acc_status = 4'b0011;
        bus_in     = 8'hC3;
        issue(2'd0, 8'h11, 5'h00, 8'h00, 4'h0, 1'b0, 1'b1);
        prev = accept_cycle;
        issue(2'd1, 8'h00, 5'h1F, 8'h00, 4'b0011, 1'b0, 1'b1);
        checks++;
        if (accept_cycle - prev !== 3) begin
            errors++;
            $display("FAIL b2b_spacing_1 cycles=%0d required 3", accept_cycle - prev);
        end
        prev = accept_cycle;
        issue(2'd2, 8'h00, 5'h00, 8'hC3, 4'h0, 1'b0, 1'b1);
        checks++;
        if (accept_cycle - prev !== 3) begin
            errors++;
            $display("FAIL b2b_spacing_2 cycles=%0d required 3", accept_cycle - prev);
        end
        prev = accept_cycle;
        issue(2'd0, 8'h22, 5'h00, 8'h00, 4'h0, 1'b0, 1'b1);
        checks++;
        if (accept_cycle - prev !== 3) begin
            errors++;
            $display("FAIL b2b_spacing_3 cycles=%0d required 3", accept_cycle - prev);
        end
        repeat (3) @(posedge clk);
        #1;
        acc_status = 4'h0;
        bus_in     = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 2'd0;
        cmd_data   = '0;
        cmd_alu_op = '0;
        rsp_ready  = 1'b1;
        acc_status = 4'h0;
        bus_in     = '0;

        test_reset();
        test_load();
        test_exec();
        test_store();
        test_illegal();
        test_backpressure();
        test_back_to_back();

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
